reg_circuit_bypass: RTL

- Parametrised successor to the decode-stage register circuit.
- Contains a register file with two read ports and one write port, plus the Reg2Loc source-2 selector.
- Writes on the rising clock edge. Same-cycle read-after-write is served by an explicit write-through bypass rather than an inverted write clock.
- Adds a per-register busy scoreboard that raises a stall when a source register still has an in-flight producer.
- Sits between instruction decode and the ID/EX pipeline register.

---
 rtl/reg_circuit_bypass_if.sv | 45 ++++
 rtl/reg_circuit_bypass.sv | 104 ++++++++++
 2 files changed

// File: rtl/reg_circuit_bypass_if.sv
// Decode-stage register circuit bus.
// Carries the read-address selection, the writeback write port, the issue
// notification for the busy scoreboard, and the read data / stall results.
//
// Signals:
//   Rn, Rm, Rd_read, Reg2Loc     read port addressing (port 2 picks Rm or Rd_read)
//   Rd_write, RegWrite, RegDataIn writeback write port
//   IssueValid, IssueRd           destination of the instruction leaving decode
//   D1, D2                        read data for port 1 and port 2
//   Stall                         a source operand still waits on its producer
//
// Modports:
//   master  decode/writeback side, drives addresses and data, receives results
//   slave   register circuit side
interface reg_circuit_bypass_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] Rn;
    logic [ADDR_W-1:0] Rm;
    logic [ADDR_W-1:0] Rd_read;
    logic              Reg2Loc;
    logic [ADDR_W-1:0] Rd_write;
    logic              RegWrite;
    logic [DATA_W-1:0] RegDataIn;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueRd;
    logic [DATA_W-1:0] D1;
    logic [DATA_W-1:0] D2;
    logic              Stall;

    modport master (
        output Rn, Rm, Rd_read, Reg2Loc,
        output Rd_write, RegWrite, RegDataIn,
        output IssueValid, IssueRd,
        input  D1, D2, Stall
    );

    modport slave (
        input  Rn, Rm, Rd_read, Reg2Loc,
        input  Rd_write, RegWrite, RegDataIn,
        input  IssueValid, IssueRd,
        output D1, D2, Stall
    );
endinterface

// File: rtl/reg_circuit_bypass.sv
// Decode-stage register circuit with write-through bypass and busy scoreboard.
// Two combinational read ports, one write port written on the rising edge,
// the Reg2Loc source-2 selector, and a per-register busy bit that raises
// Stall while a source register still has an outstanding producer.
//
// Ports:
//   clk      system clock, all state changes on the rising edge
//   reset_n  asynchronous active-low reset, clears registers and busy bits
//   bus      reg_circuit_bypass_if slave modport (addresses, write port,
//            issue notification, D1/D2 read data, Stall)
//
// Parameters:
//   DATA_W       register width
//   ADDR_W       address width, depth is 2**ADDR_W
//   ZERO_REG_EN  highest register reads 0, ignores writes, never busy
//   BYPASS_EN    forward same-cycle write data to the read ports
module reg_circuit_bypass #(
    parameter int DATA_W      = 64,
    parameter int ADDR_W      = 5,
    parameter int ZERO_REG_EN = 1,
    parameter int BYPASS_EN   = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    reg_circuit_bypass_if.slave bus
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '1;
    localparam bit                ZERO_ON   = (ZERO_REG_EN != 0);
    localparam bit                BYPASS_ON = (BYPASS_EN != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [ADDR_W-1:0] src2;
    logic              writeAllowed;
    logic              hit1;
    logic              hit2;

    function automatic logic isZero(input logic [ADDR_W-1:0] a);
        return ZERO_ON && (a == ZERO_ADDR);
    endfunction

    assign src2         = bus.Reg2Loc ? bus.Rm : bus.Rd_read;
    assign writeAllowed = bus.RegWrite && !isZero(bus.Rd_write);

    // A bypass hit means the writeback in flight this cycle targets the read
    // address; it both supplies the data and satisfies any pending busy bit.
    assign hit1 = BYPASS_ON && bus.RegWrite && (bus.Rd_write == bus.Rn);
    assign hit2 = BYPASS_ON && bus.RegWrite && (bus.Rd_write == src2);

    // Register storage. The zero register is never written, so it stays at
    // its reset value of 0 even though reads also force it to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (writeAllowed) begin
            mem[bus.Rd_write] <= bus.RegDataIn;
        end
    end

    // Scoreboard next state. The clear is applied first so that an issue to
    // the same register in the same cycle wins: the new producer supersedes
    // the one that is just retiring.
    always_comb begin
        busyNext = busy;
        if (bus.RegWrite) begin
            busyNext[bus.Rd_write] = 1'b0;
        end
        if (bus.IssueValid && !isZero(bus.IssueRd)) begin
            busyNext[bus.IssueRd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            busy <= busyNext;
        end
    end

    // Read ports and stall. Everything is forced to 0 while reset is held so
    // a writeback presented during reset cannot leak through the bypass.
    always_comb begin
        bus.D1    = '0;
        bus.D2    = '0;
        bus.Stall = 1'b0;
        if (reset_n) begin
            if (!isZero(bus.Rn)) begin
                bus.D1 = hit1 ? bus.RegDataIn : mem[bus.Rn];
            end
            if (!isZero(src2)) begin
                bus.D2 = hit2 ? bus.RegDataIn : mem[src2];
            end
            bus.Stall = (busy[bus.Rn] && !hit1) || (busy[src2] && !hit2);
        end
    end

endmodule
